// File: rtl/smbm_ctrl.sv
// Arbitration front-end for a shared smbm: round-robin accepts one requester at a time,
// screens ADD/DELETE against live occupancy, issues a one-cycle opcode and waits for done.
module smbm_ctrl #(
   parameter int NUM_REQ            = 4,
   parameter int TIMEOUT            = 16,
   parameter int BIT_VEC_SIZE       = 512,
   parameter int BIT_VEC_SIZE_LOG   = 9,
   parameter int NUM_OF_METRICS     = 8,
   parameter int NUM_OF_METRICS_LOG = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_REQ-1:0]                     req_valid,
   input  logic [NUM_REQ*3-1:0]                   req_op,
   input  logic [NUM_REQ*BIT_VEC_SIZE_LOG-1:0]    req_id,
   input  logic [NUM_REQ*NUM_OF_METRICS*8-1:0]    req_metric_val,
   input  logic [NUM_REQ*BIT_VEC_SIZE-1:0]        req_in,
   input  logic [NUM_REQ*NUM_OF_METRICS_LOG-1:0]  req_metricX,
   input  logic [NUM_REQ*3-1:0]                   req_rmode,
   output logic [NUM_REQ-1:0]                     req_ready,
   output logic [NUM_REQ-1:0]                     rsp_valid,
   output logic [1:0]                             rsp_status,
   output logic [2:0]                             smbm_opcode,
   output logic [BIT_VEC_SIZE_LOG-1:0]            smbm_id,
   output logic [NUM_OF_METRICS*8-1:0]            smbm_metric_val,
   output logic [BIT_VEC_SIZE-1:0]                smbm_in,
   output logic [NUM_OF_METRICS_LOG-1:0]          smbm_metricX,
   output logic [2:0]                             smbm_opcode_in,
   output logic                                   smbm_rst,
   input  logic                                   smbm_done,
   output logic [BIT_VEC_SIZE_LOG:0]              occupancy,
   output logic                                   busy,
   output logic [1:0]                             state_dbg
);

   localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int OCC_W = BIT_VEC_SIZE_LOG + 1;
   localparam int MV_W  = NUM_OF_METRICS * 8;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BIT_VEC_SIZE);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_DEL  = 3'b001;
   localparam logic [2:0] OP_READ = 3'b010;
   localparam logic [2:0] OP_NOP  = 3'b111;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_FULL  = 2'b01;
   localparam logic [1:0] ST_EMPTY = 2'b10;
   localparam logic [1:0] ST_ERR   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                         state_q, state_d;
   logic [RR_W-1:0]                rr_q, rr_d, g_q, g_d;
   logic [OCC_W-1:0]               occ_q, occ_d;
   logic [1:0]                     status_q, status_d;
   logic [TO_W-1:0]                wait_cnt_q, wait_cnt_d;
   logic [2:0]                     op_q, op_d, rmode_q, rmode_d;
   logic [BIT_VEC_SIZE_LOG-1:0]    id_q, id_d;
   logic [MV_W-1:0]                mval_q, mval_d;
   logic [BIT_VEC_SIZE-1:0]        in_q, in_d;
   logic [NUM_OF_METRICS_LOG-1:0]  mx_q, mx_d;

   logic [NUM_REQ-1:0]             rot;
   logic                           grant_any;
   logic [RR_W-1:0]                grant_pos, grant_idx;
   logic [RR_W:0]                  grant_sum;
   logic [2:0]                     sel_op, sel_rmode;
   logic [BIT_VEC_SIZE_LOG-1:0]    sel_id;
   logic [MV_W-1:0]                sel_mval;
   logic [BIT_VEC_SIZE-1:0]        sel_in;
   logic [NUM_OF_METRICS_LOG-1:0]  sel_mx;

   // Rotate so bit 0 is the requester at rr_q, pick the first set bit, rotate back.
   always_comb begin
      rot       = NUM_REQ'({req_valid, req_valid} >> rr_q);
      grant_any = 1'b0;
      grant_pos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_any && rot[i]) begin
            grant_any = 1'b1;
            grant_pos = RR_W'(i);
         end
      end
      grant_sum = {1'b0, grant_pos} + {1'b0, rr_q};
      if (grant_sum >= (RR_W+1)'(NUM_REQ)) grant_sum = grant_sum - (RR_W+1)'(NUM_REQ);
      grant_idx = grant_sum[RR_W-1:0];
   end

   always_comb begin
      sel_op    = OP_NOP;
      sel_rmode = '0;
      sel_id    = '0;
      sel_mval  = '0;
      sel_in    = '0;
      sel_mx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == RR_W'(i)) begin
            sel_op    = req_op[3*i +: 3];
            sel_rmode = req_rmode[3*i +: 3];
            sel_id    = req_id[BIT_VEC_SIZE_LOG*i +: BIT_VEC_SIZE_LOG];
            sel_mval  = req_metric_val[MV_W*i +: MV_W];
            sel_in    = req_in[BIT_VEC_SIZE*i +: BIT_VEC_SIZE];
            sel_mx    = req_metricX[NUM_OF_METRICS_LOG*i +: NUM_OF_METRICS_LOG];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      g_d        = g_q;
      occ_d      = occ_q;
      status_d   = status_q;
      wait_cnt_d = wait_cnt_q;
      op_d       = op_q;
      rmode_d    = rmode_q;
      id_d       = id_q;
      mval_d     = mval_q;
      in_d       = in_q;
      mx_d       = mx_q;
      req_ready  = '0;
      rsp_valid  = '0;
      case (state_q)
         S_IDLE: begin
            // No grant while rst is high, so a reset cycle never swallows a request.
            if (grant_any && !rst) begin
               req_ready[grant_idx] = 1'b1;
               g_d        = grant_idx;
               op_d       = sel_op;
               rmode_d    = sel_rmode;
               id_d       = sel_id;
               mval_d     = sel_mval;
               in_d       = sel_in;
               mx_d       = sel_mx;
               wait_cnt_d = '0;
               if (sel_op != OP_ADD && sel_op != OP_DEL && sel_op != OP_READ) begin
                  status_d = ST_ERR;
                  state_d  = S_RESP;
               end else if (sel_op == OP_ADD && occ_q == OCC_FULL) begin
                  status_d = ST_FULL;
                  state_d  = S_RESP;
               end else if (sel_op == OP_DEL && occ_q == '0) begin
                  status_d = ST_EMPTY;
                  state_d  = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (smbm_done) begin
               status_d = ST_OK;
               state_d  = S_RESP;
               if (op_q == OP_ADD)      occ_d = occ_q + 1'b1;
               else if (op_q == OP_DEL) occ_d = occ_q - 1'b1;
            end else if (wait_cnt_q == TO_LAST) begin
               status_d = ST_ERR;
               state_d  = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid[g_q] = 1'b1;
            rr_d    = (g_q == RR_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rr_q       <= '0;
         g_q        <= '0;
         occ_q      <= '0;
         status_q   <= ST_OK;
         wait_cnt_q <= '0;
         op_q       <= OP_NOP;
         rmode_q    <= '0;
         id_q       <= '0;
         mval_q     <= '0;
         in_q       <= '0;
         mx_q       <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         g_q        <= g_d;
         occ_q      <= occ_d;
         status_q   <= status_d;
         wait_cnt_q <= wait_cnt_d;
         op_q       <= op_d;
         rmode_q    <= rmode_d;
         id_q       <= id_d;
         mval_q     <= mval_d;
         in_q       <= in_d;
         mx_q       <= mx_d;
      end
   end

   assign smbm_opcode     = (state_q == S_ISSUE) ? op_q : OP_NOP;
   assign smbm_id         = id_q;
   assign smbm_metric_val = mval_q;
   assign smbm_in         = in_q;
   assign smbm_metricX    = mx_q;
   assign smbm_opcode_in  = rmode_q;
   assign smbm_rst        = rst;
   assign rsp_status      = status_q;
   assign occupancy       = occ_q;
   assign busy            = (state_q != S_IDLE);
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_smbm_ctrl.sv
// Bench for smbm_ctrl: randomized requests, a cycle-level smbm stand-in, and a scoreboard
// holding the expected requester/status/occupancy/response cycle for every accept.
module tb_smbm_ctrl;
  localparam int N   = 4;
  localparam int BV  = 512;
  localparam int BVL = 9;
  localparam int NM  = 8;
  localparam int NML = 3;
  localparam int TO  = 16;
  localparam int W   = 46;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]        req_valid;
  logic [N*3-1:0]      req_op, req_rmode;
  logic [N*BVL-1:0]    req_id;
  logic [N*NM*8-1:0]   req_metric_val;
  logic [N*BV-1:0]     req_in;
  logic [N*NML-1:0]    req_metricX;
  logic [N-1:0]        req_ready, rsp_valid;
  logic [1:0]          rsp_status, state_dbg;
  logic [2:0]          smbm_opcode, smbm_opcode_in;
  logic [BVL-1:0]      smbm_id;
  logic [NM*8-1:0]     smbm_metric_val;
  logic [BV-1:0]       smbm_in;
  logic [NML-1:0]      smbm_metricX;
  logic                smbm_rst, smbm_done, busy;
  logic [BVL:0]        occupancy;

  smbm_ctrl #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_id(req_id),
    .req_metric_val(req_metric_val), .req_in(req_in), .req_metricX(req_metricX),
    .req_rmode(req_rmode), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .smbm_opcode(smbm_opcode), .smbm_id(smbm_id),
    .smbm_metric_val(smbm_metric_val), .smbm_in(smbm_in), .smbm_metricX(smbm_metricX),
    .smbm_opcode_in(smbm_opcode_in), .smbm_rst(smbm_rst), .smbm_done(smbm_done),
    .occupancy(occupancy), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // smbm stand-in: done two cycles after the opcode is seen, optional stray pulses in IDLE
  bit done_en  = 1'b1;
  bit stray_en = 1'b0;
  int done_at  = -1;
  initial forever begin
    @(negedge clk);
    if (smbm_opcode != 3'b111) done_at = cyc + 2;
  end
  initial begin
    smbm_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      smbm_done = (done_en && cyc == done_at) || (stray_en && !busy && $urandom_range(0, 3) == 0);
    end
  end

  // reference model state
  logic [W-1:0] exp_q[$];
  int m_rr = 0;
  int m_occ = 0;
  bit m_busy = 1'b0;
  int issue_cyc = -1;
  logic [2:0]  issue_op;
  logic [8:0]  issue_id;
  logic [63:0] issue_mv, issue_in;
  logic [5:0]  issue_sel;

  task automatic mon_step();
    int w, lat, occn;
    logic [2:0] op;
    logic [1:0] st;
    logic [W-1:0] e;
    if (rst) begin
      chk("ready_in_reset", req_ready, 0);
      return;
    end
    chk("busy", busy, m_busy);
    chk("smbm_opcode", smbm_opcode, (cyc == issue_cyc) ? issue_op : 3'b111);
    if (cyc == issue_cyc) begin
      chk("smbm_id", smbm_id, issue_id);
      chk("smbm_metric_val", smbm_metric_val, issue_mv);
      chk("smbm_in", smbm_in[63:0], issue_in);
      chk("smbm_sel", {smbm_metricX, smbm_opcode_in}, issue_sel);
    end
    if (!m_busy && req_valid != 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      chk("grant", req_ready, 64'(1) << w);
      op = req_op[w*3 +: 3];
      occn = m_occ;
      lat = 1;
      if (op > 3'd2) st = 2'b11;
      else if (op == 3'd0 && m_occ == BV) st = 2'b01;
      else if (op == 3'd1 && m_occ == 0) st = 2'b10;
      else begin
        issue_cyc = cyc + 1;
        issue_op  = op;
        issue_id  = req_id[w*BVL +: BVL];
        issue_mv  = req_metric_val[w*64 +: 64];
        issue_in  = req_in[w*BV +: 64];
        issue_sel = {req_metricX[w*3 +: 3], req_rmode[w*3 +: 3]};
        if (done_en) begin
          st = 2'b00;
          lat = 4;
          if (op == 3'd0) occn = m_occ + 1;
          else if (op == 3'd1) occn = m_occ - 1;
        end else begin
          st = 2'b11;
          lat = 2 + TO;
        end
      end
      m_occ = occn;
      m_busy = 1'b1;
      exp_q.push_back({32'(cyc + lat), 10'(occn), st, 2'(w)});
    end else begin
      chk("no_grant", req_ready, 0);
    end
    if (rsp_valid != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", rsp_valid, 64'(1) << e[1:0]);
        chk("rsp_status", rsp_status, e[3:2]);
        chk("occupancy", occupancy, e[13:4]);
        chk("rsp_cycle", cyc, e[45:14]);
        m_rr = (int'(e[1:0]) + 1) % N;
        m_busy = 1'b0;
      end
    end
  endtask

  initial forever begin @(negedge clk); mon_step(); end

  // driver tasks
  task automatic set_args(input int r, input logic [2:0] op, input logic [8:0] id, input bit fixed_mv);
    req_op[r*3 +: 3]         = op;
    req_id[r*BVL +: BVL]     = id;
    req_metric_val[r*64 +: 64] = fixed_mv ? {8{8'h10}} : {$urandom, $urandom};
    for (int k = 0; k < 16; k++) req_in[r*BV + k*32 +: 32] = $urandom;
    req_metricX[r*3 +: 3]    = 3'($urandom_range(0, 7));
    req_rmode[r*3 +: 3]      = 3'($urandom_range(0, 7));
  endtask

  task automatic launch(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int budget;
    @(posedge clk); #1;
    pend = mask;
    req_valid = mask;
    budget = 0;
    while (pend != 0 && budget < 200) begin
      @(negedge clk);
      pend = pend & ~req_ready;
      @(posedge clk); #1;
      req_valid = pend;
      budget++;
    end
    if (pend != 0) begin
      chk("accept_timeout", pend, 0);
      req_valid = '0;
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((m_busy || exp_q.size() != 0 || req_valid != 0) && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) chk("idle_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    exp_q.delete();
    m_busy = 1'b0;
    m_rr = 0;
    m_occ = 0;
    issue_cyc = -1;
    done_at = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_smbm_opcode", smbm_opcode, 3'b111);
    chk("rst_state", state_dbg, 0);
  endtask

  function automatic logic [2:0] rand_op();
    int v;
    v = $urandom_range(0, 9);
    if (v < 4) return 3'b000;
    if (v < 6) return 3'b001;
    if (v < 8) return 3'b010;
    return 3'($urandom_range(3, 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_op = '0; req_id = '0; req_metric_val = '0;
    req_in = '0; req_metricX = '0; req_rmode = '0;
    repeat (3) @(posedge clk);
    do_reset();

    // single ADD from requester 0, fixed metrics
    set_args(0, 3'b000, 9'd5, 1'b1);
    launch(4'b0001);
    wait_idle();
    chk("add_occupancy", occupancy, 1);

    // four simultaneous ADDs from reset: grants 0,1,2,3
    do_reset();
    for (int r = 0; r < N; r++) set_args(r, 3'b000, 9'(10 + r), 1'b0);
    launch(4'b1111);
    wait_idle();
    chk("four_add_occupancy", occupancy, 4);

    // rejected ops at occupancy 0
    do_reset();
    set_args(2, 3'b001, 9'd7, 1'b0);
    launch(4'b0100);
    wait_idle();
    set_args(1, 3'b110, 9'd3, 1'b0);
    launch(4'b0010);
    wait_idle();

    // randomized traffic with stray done pulses
    stray_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, 15));
      for (int r = 0; r < N; r++) if (mask[r]) set_args(r, rand_op(), 9'($urandom_range(0, 511)), 1'b0);
      launch(mask);
      wait_idle();
    end
    stray_en = 1'b0;

    // READ with smbm never answering
    done_en = 1'b0;
    set_args(1, 3'b010, 9'd0, 1'b0);
    launch(4'b0010);
    wait_idle();
    chk("idle_after_timeout", state_dbg, 0);

    // ADD so occupancy is nonzero, then reset while waiting
    done_en = 1'b1;
    set_args(0, 3'b000, 9'd44, 1'b0);
    launch(4'b0001);
    wait_idle();
    done_en = 1'b0;
    set_args(3, 3'b000, 9'd99, 1'b0);
    launch(4'b1000);
    chk("busy_before_abort", busy, 1);
    do_reset();
    repeat (3) @(negedge clk);
    done_en = 1'b1;

    // fill to capacity, then FULL, then one DELETE
    for (int i = 0; i < BV; i++) begin
      set_args(1, 3'b000, 9'(i), 1'b0);
      launch(4'b0010);
    end
    wait_idle();
    chk("full_occupancy", occupancy, BV);
    set_args(2, 3'b000, 9'd1, 1'b0);
    launch(4'b0100);
    wait_idle();
    chk("full_occupancy_kept", occupancy, BV);
    set_args(0, 3'b001, 9'd1, 1'b0);
    launch(4'b0001);
    wait_idle();
    chk("after_delete_occupancy", occupancy, BV - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
